// File: rtl/chess_pkg.sv
// Shared board-encoding types and constants for the board load bus and the UCI move format.
// Pure declarations; no logic, no latency, no flow control.
// Castling support in users of this package is selected by BOARD_EMIT_CASTLE_EN.
package chess_pkg;

    typedef enum logic [2:0] {
        PC_NONE   = 3'd0,
        PC_KING   = 3'd1,
        PC_QUEEN  = 3'd2,
        PC_ROOK   = 3'd3,
        PC_BISHOP = 3'd4,
        PC_KNIGHT = 3'd5,
        PC_PAWN   = 3'd6
    } piece_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_EMIT  = 2'd2
    } emit_state_e;

    // UCI move fields, LSB offsets; the 18 used bits are right-aligned in the 20-bit word.
    localparam int MV_W       = 20;
    localparam int FLD_W      = 3;
    localparam int PROMOTE_W  = 2;
    localparam int MV_TO_F    = 0;
    localparam int MV_TO_R    = 3;
    localparam int MV_TAKES   = 6;
    localparam int MV_FROM_F  = 7;
    localparam int MV_FROM_R  = 10;
    localparam int MV_PIECE   = 13;
    localparam int MV_PROMOTE = 16;

    // Castle rights vector is {K,Q,k,q}.
    localparam int CASTLE_K  = 3;
    localparam int CASTLE_Q  = 2;
    localparam int CASTLE_BK = 1;
    localparam int CASTLE_BQ = 0;

`ifdef BOARD_EMIT_CASTLE_EN
    localparam logic [3:0] CASTLE_RST = 4'hF;
`else
    localparam logic [3:0] CASTLE_RST = 4'h0;
`endif

    // Nibble per square at [sq*4 +: 4], sq = rank*8 + file; top word is rank 8.
    localparam logic [255:0] START_POS = {
        32'h35412453,
        32'h66666666,
        32'h00000000,
        32'h00000000,
        32'h00000000,
        32'h00000000,
        32'hEEEEEEEE,
        32'hBDC9ACDB
    };

    function automatic logic [5:0] sq_idx(input logic [2:0] rank, input logic [2:0] file);
        return {rank, file};
    endfunction

endpackage

// File: rtl/board_move_decode.sv
// Combinational move decode: square write enables/data plus next side-to-move, castle and ep state.
// Zero latency; no flow control, consumed by the owner in its single apply cycle.
// BOARD_EMIT_CASTLE_EN adds rook relocation and castle-right bookkeeping.
module board_move_decode
    import chess_pkg::*;
(
    input  logic [19:0]  mv,
    input  logic [255:0] board,
    input  logic         wtp,
    input  logic [3:0]   castle,
    input  logic [2:0]   ep,
    output logic [63:0]  sq_we,
    output logic [255:0] sq_wd,
    output logic         wtp_nxt,
    output logic [3:0]   castle_nxt,
    output logic [2:0]   ep_nxt,
    output logic         ep_valid_nxt
);

    logic [1:0] promote;
    piece_e     piece;
    logic [2:0] from_r;
    logic [2:0] from_f;
    logic [2:0] to_r;
    logic [2:0] to_f;
    logic       takes;
    logic [5:0] from_sq;
    logic [5:0] to_sq;
    logic [5:0] ep_sq;
    logic [3:0] dr;
    logic       is_pawn;
    logic       promo;
    logic       tgt_empty;
    logic       ep_cap;
    logic       dbl;
    piece_e     promo_pc;
    piece_e     to_pc;

    assign promote = mv[MV_PROMOTE +: PROMOTE_W];
    assign piece   = piece_e'(mv[MV_PIECE +: FLD_W]);
    assign from_r  = mv[MV_FROM_R +: FLD_W];
    assign from_f  = mv[MV_FROM_F +: FLD_W];
    assign to_r    = mv[MV_TO_R +: FLD_W];
    assign to_f    = mv[MV_TO_F +: FLD_W];
    assign takes   = mv[MV_TAKES];

    assign from_sq = sq_idx(from_r, from_f);
    assign to_sq   = sq_idx(to_r, to_f);
    assign ep_sq   = sq_idx(from_r, to_f);

    assign is_pawn   = (piece == PC_PAWN);
    assign promo     = is_pawn && (wtp ? (to_r == 3'd7) : (to_r == 3'd0));
    assign tgt_empty = (board[{to_sq, 2'b00} +: 3] == 3'd0);
    // A diagonal pawn step onto an empty square can only be an en-passant capture.
    assign ep_cap    = is_pawn && (to_f != from_f) && !takes && tgt_empty;
    assign dr        = {1'b0, to_r} - {1'b0, from_r};
    assign dbl       = is_pawn && ((dr == 4'd2) || (dr == 4'd14));

    always_comb begin
        case (promote)
            2'd0:    promo_pc = PC_QUEEN;
            2'd1:    promo_pc = PC_BISHOP;
            2'd2:    promo_pc = PC_ROOK;
            default: promo_pc = PC_KNIGHT;
        endcase
    end

    assign to_pc = promo ? promo_pc : piece;

`ifdef BOARD_EMIT_CASTLE_EN
    logic is_king;
    logic castle_ks;
    logic castle_qs;
    assign is_king   = (piece == PC_KING);
    assign castle_ks = is_king && (from_f == 3'd4) && (to_f == 3'd6);
    assign castle_qs = is_king && (from_f == 3'd4) && (to_f == 3'd2);
`endif

    // Later writes win: from-clear, ep victim, rook hop, then the destination.
    always_comb begin
        sq_we = '0;
        sq_wd = '0;
        sq_we[from_sq] = 1'b1;
        if (ep_cap) begin
            sq_we[ep_sq] = 1'b1;
        end
`ifdef BOARD_EMIT_CASTLE_EN
        if (castle_ks) begin
            sq_we[sq_idx(from_r, 3'd7)] = 1'b1;
            sq_we[sq_idx(from_r, 3'd5)] = 1'b1;
            sq_wd[{sq_idx(from_r, 3'd5), 2'b00} +: 4] = {wtp, PC_ROOK};
        end else if (castle_qs) begin
            sq_we[sq_idx(from_r, 3'd0)] = 1'b1;
            sq_we[sq_idx(from_r, 3'd3)] = 1'b1;
            sq_wd[{sq_idx(from_r, 3'd3), 2'b00} +: 4] = {wtp, PC_ROOK};
        end
`endif
        sq_we[to_sq] = 1'b1;
        sq_wd[{to_sq, 2'b00} +: 4] = {wtp, to_pc};
    end

    always_comb begin
        castle_nxt = castle;
`ifdef BOARD_EMIT_CASTLE_EN
        if (is_king) begin
            if (wtp) begin
                castle_nxt[CASTLE_K] = 1'b0;
                castle_nxt[CASTLE_Q] = 1'b0;
            end else begin
                castle_nxt[CASTLE_BK] = 1'b0;
                castle_nxt[CASTLE_BQ] = 1'b0;
            end
        end
        if ((from_sq == 6'd0) || (to_sq == 6'd0)) castle_nxt[CASTLE_Q] = 1'b0;
        if ((from_sq == 6'd7) || (to_sq == 6'd7)) castle_nxt[CASTLE_K] = 1'b0;
        if ((from_sq == 6'd56) || (to_sq == 6'd56)) castle_nxt[CASTLE_BQ] = 1'b0;
        if ((from_sq == 6'd63) || (to_sq == 6'd63)) castle_nxt[CASTLE_BK] = 1'b0;
`endif
    end

    assign wtp_nxt      = ~wtp;
    assign ep_valid_nxt = dbl;
    assign ep_nxt       = dbl ? from_f : ep;

endmodule

// File: rtl/board_pos_emitter.sv
// Board state holder: applies UCI moves and streams the 64 squares a8..h1 onto the board-load bus.
// Move: accept T, apply T+1, sop T+2, eop T+65; emit pulse: sop one cycle later.
// mv_ready only in IDLE; the stream has no backpressure. BOARD_EMIT_CASTLE_EN enables castling.
module board_pos_emitter
    import chess_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        mv_valid,
    input  logic [19:0] mv_data,
    output logic        mv_ready,
    input  logic        emit,
    output logic        out_pos_valid,
    output logic [3:0]  out_pos_data,
    output logic        out_pos_sop,
    output logic        out_pos_eop,
    output logic        out_wtp,
    output logic [3:0]  out_castle,
    output logic [2:0]  out_ep,
    output logic        out_ep_valid,
    output logic        busy
);

    emit_state_e  state;
    emit_state_e  state_nxt;
    logic [5:0]   k;
    logic         live;
    logic         idle;
    logic [255:0] board;
    logic [19:0]  mv_q;
    logic [5:0]   emit_sq;

    logic [63:0]  sq_we;
    logic [255:0] sq_wd;
    logic         wtp_nxt;
    logic [3:0]   castle_nxt;
    logic [2:0]   ep_nxt;
    logic         ep_valid_nxt;

    // Keeps mv_ready low while reset is asserted and for the first cycle after release.
    assign idle = (state == S_IDLE) && live;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (idle && !init) begin
                    if (mv_valid)  state_nxt = S_APPLY;
                    else if (emit) state_nxt = S_EMIT;
                end
            end
            S_APPLY: state_nxt = S_EMIT;
            S_EMIT:  if (k == 6'd63) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k     <= '0;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
            k     <= (state == S_EMIT) ? k + 6'd1 : 6'd0;
        end
    end

    board_move_decode u_dec (
        .mv           (mv_q),
        .board        (board),
        .wtp          (out_wtp),
        .castle       (out_castle),
        .ep           (out_ep),
        .sq_we        (sq_we),
        .sq_wd        (sq_wd),
        .wtp_nxt      (wtp_nxt),
        .castle_nxt   (castle_nxt),
        .ep_nxt       (ep_nxt),
        .ep_valid_nxt (ep_valid_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board        <= START_POS;
            mv_q         <= '0;
            out_wtp      <= 1'b1;
            out_castle   <= CASTLE_RST;
            out_ep       <= '0;
            out_ep_valid <= 1'b0;
        end else if (idle && init) begin
            board        <= START_POS;
            out_wtp      <= 1'b1;
            out_castle   <= CASTLE_RST;
            out_ep       <= '0;
            out_ep_valid <= 1'b0;
        end else if (idle && mv_valid) begin
            mv_q <= mv_data;
        end else if (state == S_APPLY) begin
            for (int s = 0; s < 64; s++) begin
                if (sq_we[s]) board[s*4 +: 4] <= sq_wd[s*4 +: 4];
            end
            out_wtp      <= wtp_nxt;
            out_castle   <= castle_nxt;
            out_ep       <= ep_nxt;
            out_ep_valid <= ep_valid_nxt;
        end
    end

    // FEN order: beat k reads rank 7-k/8, file k%8.
    assign emit_sq       = {~k[5:3], k[2:0]};
    assign out_pos_valid = (state == S_EMIT);
    assign out_pos_data  = out_pos_valid ? board[{emit_sq, 2'b00} +: 4] : 4'h0;
    assign out_pos_sop   = out_pos_valid && (k == 6'd0);
    assign out_pos_eop   = out_pos_valid && (k == 6'd63);
    assign mv_ready      = idle;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_board_pos_emitter.sv
// Directed bench for board_pos_emitter: start position, pawn moves, en passant, promotion,
// castling (both builds of BOARD_EMIT_CASTLE_EN) and asynchronous reset mid-stream.
module tb_board_pos_emitter;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic        mv_valid;
    logic [19:0] mv_data;
    logic        mv_ready;
    logic        emit;
    logic        out_pos_valid;
    logic [3:0]  out_pos_data;
    logic        out_pos_sop;
    logic        out_pos_eop;
    logic        out_wtp;
    logic [3:0]  out_castle;
    logic [2:0]  out_ep;
    logic        out_ep_valid;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int lat;
    logic [3:0] beats [64];

`ifdef BOARD_EMIT_CASTLE_EN
    localparam logic [3:0] CASTLE_START = 4'hF;
    localparam bit         CASTLE_ON    = 1'b1;
`else
    localparam logic [3:0] CASTLE_START = 4'h0;
    localparam bit         CASTLE_ON    = 1'b0;
`endif

    board_pos_emitter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init          (init),
        .mv_valid      (mv_valid),
        .mv_data       (mv_data),
        .mv_ready      (mv_ready),
        .emit          (emit),
        .out_pos_valid (out_pos_valid),
        .out_pos_data  (out_pos_data),
        .out_pos_sop   (out_pos_sop),
        .out_pos_eop   (out_pos_eop),
        .out_wtp       (out_wtp),
        .out_castle    (out_castle),
        .out_ep        (out_ep),
        .out_ep_valid  (out_ep_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int pr, input int pc, input int fr, input int ff,
                                       input int tk, input int tr, input int tf);
        return {2'b00, 2'(pr), 3'(pc), 3'(fr), 3'(ff), 1'(tk), 3'(tr), 3'(tf)};
    endfunction

    function automatic int bi(input int r, input int f);
        return (7 - r) * 8 + f;
    endfunction

    function automatic logic [3:0] start_sq(input int r, input int f);
        logic [3:0] back [8];
        back = '{4'd3, 4'd5, 4'd4, 4'd2, 4'd1, 4'd4, 4'd5, 4'd3};
        case (r)
            0:       return 4'h8 | back[f];
            1:       return 4'hE;
            6:       return 4'h6;
            7:       return back[f];
            default: return 4'h0;
        endcase
    endfunction

    task automatic check_start(input string tag);
        int n;
        n = 0;
        for (int r = 0; r < 8; r++)
            for (int f = 0; f < 8; f++)
                if (beats[bi(r, f)] !== start_sq(r, f)) n++;
        chk(tag, n, 0);
    endtask

    // Pulses a move and/or emit in IDLE, then captures one 64-beat emission.
    task automatic run(input bit do_mv, input bit do_emit, input logic [19:0] d, output int l);
        int nv;
        int stray;
        @(negedge clk);
        mv_valid = do_mv;
        mv_data  = d;
        emit     = do_emit;
        @(negedge clk);
        mv_valid = 1'b0;
        emit     = 1'b0;
        if (do_mv) chk("apply_ready_low", mv_ready, 0);
        l = 1;
        while (!out_pos_valid && l < 8) begin
            @(negedge clk);
            l++;
        end
        if (!out_pos_valid) begin
            chk("first_beat_timeout", 0, 1);
            return;
        end
        nv = 0;
        stray = 0;
        for (int b = 0; b < 64; b++) begin
            beats[b] = out_pos_data;
            if (out_pos_valid) nv++;
            if (b == 0) chk("sop_beat0", out_pos_sop, 1);
            else if (out_pos_sop) stray++;
            if (b == 63) chk("eop_beat63", out_pos_eop, 1);
            else if (out_pos_eop) stray++;
            if (busy && mv_ready) stray++;
            @(negedge clk);
        end
        chk("beats_valid", nv, 64);
        chk("stray_sop_eop", stray, 0);
        chk("idle_after_eop", {busy, out_pos_valid, mv_ready}, 3'b001);
    endtask

    task automatic pulse_init();
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; init = 1'b0; mv_valid = 1'b0; mv_data = '0; emit = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_pos_valid, 0);
        chk("rst_ready", mv_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wtp", out_wtp, 1);
        chk("rst_castle", out_castle, CASTLE_START);
        chk("rst_ep", {out_ep_valid, out_ep}, 0);
        chk("rst_sop_eop_data", {out_pos_sop, out_pos_eop, out_pos_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", mv_ready, 1);

        // Start position via emit.
        run(1'b0, 1'b1, '0, lat);
        chk("emit_latency", lat, 1);
        chk("a8", beats[0], 4'h3);
        chk("e8", beats[4], 4'h1);
        chk("e1", beats[60], 4'h9);
        chk("a2", beats[48], 4'hE);
        check_start("start_board");
        chk("start_wtp", out_wtp, 1);
        chk("start_castle", out_castle, CASTLE_START);

        // e2e4 with emit raised in the same cycle: the move wins, one emission only.
        run(1'b1, 1'b1, mk(0, 6, 1, 4, 0, 3, 4), lat);
        chk("move_latency", lat, 2);
        chk("e2_empty", beats[52], 4'h0);
        chk("e4_pawn", beats[36], 4'hE);
        chk("e2e4_wtp", out_wtp, 0);
        chk("e2e4_ep", {out_ep_valid, out_ep}, {1'b1, 3'd4});

        // a7a6 single push clears the ep flag.
        run(1'b1, 1'b0, mk(0, 6, 6, 0, 0, 5, 0), lat);
        chk("a6_pawn", beats[bi(5, 0)], 4'h6);
        chk("a7a6_ep_valid", out_ep_valid, 0);
        chk("a7a6_wtp", out_wtp, 1);
        run(1'b1, 1'b0, mk(0, 6, 3, 4, 0, 4, 4), lat);
        run(1'b1, 1'b0, mk(0, 6, 6, 3, 0, 4, 3), lat);
        chk("d7d5_ep", {out_ep_valid, out_ep}, {1'b1, 3'd3});
        // e5xd6 en passant with takes=0.
        run(1'b1, 1'b0, mk(0, 6, 4, 4, 0, 5, 3), lat);
        chk("ep_d5_cleared", beats[27], 4'h0);
        chk("ep_d6_pawn", beats[19], 4'hE);
        chk("ep_e5_cleared", beats[28], 4'h0);
        chk("ep_flag_after", out_ep_valid, 0);

        // Promotion: white a7a8=rook, then black h2h1=knight.
        pulse_init();
        chk("init_wtp", out_wtp, 1);
        chk("init_ep", out_ep_valid, 0);
        run(1'b1, 1'b0, mk(2, 6, 6, 0, 0, 7, 0), lat);
        chk("promo_a8_rook", beats[0], 4'hB);
        chk("promo_a7_empty", beats[8], 4'h0);
        run(1'b1, 1'b0, mk(3, 6, 1, 7, 0, 0, 7), lat);
        chk("promo_h1_bknight", beats[63], 4'h5);
        chk("promo_h2_empty", beats[55], 4'h0);
        chk("promo_wtp", out_wtp, 1);

        // Castling king side after clearing f1/g1.
        pulse_init();
        run(1'b1, 1'b0, mk(0, 4, 0, 5, 0, 3, 2), lat);
        run(1'b1, 1'b0, mk(0, 6, 6, 0, 0, 5, 0), lat);
        run(1'b1, 1'b0, mk(0, 5, 0, 6, 0, 2, 5), lat);
        run(1'b1, 1'b0, mk(0, 6, 5, 0, 0, 4, 0), lat);
        chk("pre_castle_rights", out_castle, CASTLE_START);
        run(1'b1, 1'b0, mk(0, 1, 0, 4, 0, 0, 6), lat);
        chk("castle_g1", beats[62], 4'h9);
        chk("castle_e1", beats[60], 4'h0);
        chk("castle_f1", beats[61], CASTLE_ON ? 4'hB : 4'h0);
        chk("castle_h1", beats[63], CASTLE_ON ? 4'h0 : 4'hB);
        chk("castle_rights", out_castle, CASTLE_ON ? 4'b0011 : 4'h0);
        // Black rook leaves h8: k right drops.
        run(1'b1, 1'b0, mk(0, 3, 7, 7, 0, 5, 7), lat);
        chk("h8_rights", out_castle, CASTLE_ON ? 4'b0001 : 4'h0);
        chk("h6_brook", beats[bi(5, 7)], 4'h3);

        // Asynchronous reset at beat 20 of an emission.
        @(negedge clk);
        emit = 1'b1;
        @(negedge clk);
        emit = 1'b0;
        chk("mid_sop", out_pos_sop, 1);
        repeat (20) @(negedge clk);
        chk("mid_valid_before", out_pos_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_pos_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wtp", out_wtp, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(1'b0, 1'b1, '0, lat);
        chk("post_rst_latency", lat, 1);
        check_start("post_rst_board");
        chk("post_rst_castle", out_castle, CASTLE_START);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
